// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Arbitrates N_REQ writeback requesters onto the single register-file write
//   port.
//     Requester roles: 0 = ALU result, 1 = autoincrement, 2 = memory load.
//   Arbitration is round-robin. A requester that has lost MAX_WAIT times in a
//   row gets forced priority.
//   The winning write is registered and appears one cycle after the grant.
//   Destination routing:
//     R0-R2  -> special-register load port (the register file owns PC/SP/SR).
//     R3     -> discarded, because R3 is the constant generator.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   stall              hold from the control unit; blocks new grants
//   req_valid/da/din   per-requester write request (4-bit da, 16-bit din slices)
//   req_ready          one-hot grant
//   RW/DA/Din          register-file write port (R4-R15)
//   spec_wr/sel/data   special-register load (0=PC, 1=SP, 2=SR)
//   wr_dropped         pulse when an accepted write targeted R3
module reg_wb_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [4*N_REQ-1:0]    req_da,
    input  logic [16*N_REQ-1:0]   req_din,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  RW,
    output logic [3:0]            DA,
    output logic [15:0]           Din,
    output logic                  spec_wr,
    output logic [1:0]            spec_sel,
    output logic [15:0]           spec_data,
    output logic                  wr_dropped
);

    localparam int         PTR_W = $clog2(N_REQ);
    localparam logic [3:0] SAT   = 4'(MAX_WAIT);

    logic [PTR_W-1:0] rr_ptr;
    logic [3:0]       wait_cnt [N_REQ];
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    logic             forced_found;
    logic [3:0]       win_da;
    logic [15:0]      win_din;
    logic             xfer;

    // Grant selection. A saturated waiter (lowest index first) overrides the
    // round-robin scan, which starts just after the last winner.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        forced_found = 1'b0;
        if (!rst && !stall) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!forced_found && req_valid[i] && wait_cnt[i] == SAT) begin
                    forced_found = 1'b1;
                    grant_idx    = PTR_W'(i);
                end
            end
            grant_valid = forced_found;
            for (int k = 1; k <= N_REQ; k++) begin
                for (int j = 0; j < N_REQ; j++) begin
                    if (!grant_valid && req_valid[j] &&
                        j == (int'(rr_ptr) + k) % N_REQ) begin
                        grant_valid = 1'b1;
                        grant_idx   = PTR_W'(j);
                    end
                end
            end
        end
    end

    // One-hot ready plus a mux that selects the winner's address and data.
    always_comb begin
        req_ready = '0;
        win_da    = '0;
        win_din   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_valid && grant_idx == PTR_W'(j)) begin
                req_ready[j] = 1'b1;
                win_da       = req_da[4*j +: 4];
                win_din      = req_din[16*j +: 16];
            end
        end
    end

    assign xfer = |(req_valid & req_ready);

    // Arbitration state. The pointer resets to the last index so that
    // requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= PTR_W'(N_REQ - 1);
        end else if (xfer) begin
            rr_ptr <= grant_idx;
        end
    end

    // Wait counters. These keep counting through a stall, so a long stall
    // can leave several requesters saturated at once.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (rst || !req_valid[i] || req_ready[i]) begin
                wait_cnt[i] <= '0;
            end else if (wait_cnt[i] < SAT) begin
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
            end
        end
    end

    // Registered output stage. Strobes last one cycle. Address and data hold
    // their last values between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            RW         <= 1'b0;
            DA         <= '0;
            Din        <= '0;
            spec_wr    <= 1'b0;
            spec_sel   <= '0;
            spec_data  <= '0;
            wr_dropped <= 1'b0;
        end else begin
            RW         <= 1'b0;
            spec_wr    <= 1'b0;
            wr_dropped <= 1'b0;
            if (xfer) begin
                case (win_da)
                    4'd0: begin
                        spec_wr   <= 1'b1;
                        spec_sel  <= 2'd0;
                        spec_data <= {win_din[15:1], 1'b0};
                    end
                    4'd1, 4'd2: begin
                        spec_wr   <= 1'b1;
                        spec_sel  <= win_da[1:0];
                        spec_data <= win_din;
                    end
                    4'd3: begin
                        wr_dropped <= 1'b1;
                    end
                    default: begin
                        RW  <= 1'b1;
                        DA  <= win_da;
                        Din <= win_din;
                    end
                endcase
            end
        end
    end

endmodule
